// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: RV32 load/store func3 encodings and the memory-port arbiter state.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_D_REQ,
    ST_D_WAIT,
    ST_I_REQ,
    ST_I_WAIT
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single shared memory port: request/grant handshake plus a separate response beat.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// RV32 byte-lane logic: byte enables, store-data replication, load extraction and access legality.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        i_func3,
  input  logic [1:0]        i_lane,
  input  logic              i_store,
  input  logic [DATA_W-1:0] i_rs2,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [3:0]        o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_load_data,
  output logic              o_fault
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
  assign w_half = i_rdata[{i_lane[1], 4'b0000} +: 16];

  always_comb begin
    o_be        = 4'b0000;
    o_wdata     = '0;
    o_load_data = '0;
    o_fault     = 1'b0;
    case (i_func3)
      F3_B, F3_BU: begin
        o_be        = 4'b0001 << i_lane;
        o_wdata     = {4{i_rs2[7:0]}};
        o_load_data = (i_func3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
        // Unsigned variants only exist for loads.
        o_fault     = i_store && (i_func3 == F3_BU);
      end
      F3_H, F3_HU: begin
        o_be        = 4'b0011 << {i_lane[1], 1'b0};
        o_wdata     = {2{i_rs2[15:0]}};
        o_load_data = (i_func3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        o_fault     = i_lane[0] || (i_store && (i_func3 == F3_HU));
      end
      F3_W: begin
        o_be        = 4'b1111;
        o_wdata     = i_rs2;
        o_load_data = i_rdata;
        o_fault     = |i_lane;
      end
      default: o_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage load/store, data first,
// one transaction outstanding, and generates the pipeline stalls.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_flush,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  stall_if,
  input  logic                  me_mem_read_ena,
  input  logic                  me_mem_write_ena,
  input  logic [ADDR_W-1:0]     me_alu_out,
  input  logic [DATA_W-1:0]     me_rs2_data_st,
  input  logic [2:0]            me_func3,
  output logic [DATA_W-1:0]     me_load_data,
  output logic                  me_access_fault,
  output logic                  stall_me,
  output logic                  pipe_stall,
  mem_port_arbiter_if.master    mem
);

  arb_state_t        r_state, w_next;
  logic              r_d_served, r_i_served, r_discard, r_fault;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_load_data;
  logic [2:0]        r_func3;
  logic [1:0]        r_lane;

  logic              w_d_pend, w_i_pend, w_pipe_adv, w_idle, w_fault;
  logic [2:0]        w_func3;
  logic [1:0]        w_lane;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata, w_load;
  logic              w_align_fault;
  logic              w_unused;

  assign w_d_pend   = (me_mem_read_ena | me_mem_write_ena) & ~r_d_served;
  assign w_i_pend   = if_req & ~r_i_served;
  assign stall_me   = w_d_pend;
  assign stall_if   = w_i_pend;
  assign pipe_stall = stall_if | stall_me;
  assign w_pipe_adv = ~pipe_stall;
  assign w_unused   = ^if_addr[1:0];

  // Decode from the live MEM-stage fields in IDLE; the latched copy steers load extraction later.
  assign w_idle  = (r_state == ST_IDLE);
  assign w_func3 = w_idle ? me_func3 : r_func3;
  assign w_lane  = w_idle ? me_alu_out[1:0] : r_lane;
  assign w_fault = w_align_fault | (me_mem_read_ena & me_mem_write_ena);

  lsu_align #(.DATA_W(DATA_W)) u_lsu_align (
    .i_func3     (w_func3),
    .i_lane      (w_lane),
    .i_store     (me_mem_write_ena),
    .i_rs2       (me_rs2_data_st),
    .i_rdata     (mem.mem_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_load_data (w_load),
    .o_fault     (w_align_fault)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_d_pend) begin
          if (!w_fault) w_next = ST_D_REQ;
        end else if (w_i_pend && !if_flush) begin
          w_next = ST_I_REQ;
        end
      end
      ST_D_REQ:  if (mem.mem_gnt)    w_next = ST_D_WAIT;
      ST_D_WAIT: if (mem.mem_rvalid) w_next = ST_IDLE;
      ST_I_REQ:  if (mem.mem_gnt)    w_next = ST_I_WAIT;
      ST_I_WAIT: if (mem.mem_rvalid) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req   = (r_state == ST_D_REQ) || (r_state == ST_I_REQ);
    mem.mem_we    = r_mem_we;
    mem.mem_addr  = r_mem_addr;
    mem.mem_be    = r_mem_be;
    mem.mem_wdata = r_mem_wdata;
  end

  assign if_rdata        = r_if_rdata;
  assign me_load_data    = r_load_data;
  assign me_access_fault = r_fault;

  // Served flags and latched request fields; later assignments override the pipe_adv clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d_served  <= 1'b0;
      r_i_served  <= 1'b0;
      r_discard   <= 1'b0;
      r_fault     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_load_data <= '0;
      r_func3     <= 3'b000;
      r_lane      <= 2'b00;
    end else begin
      if (w_pipe_adv) begin
        r_d_served <= 1'b0;
        r_i_served <= 1'b0;
        r_fault    <= 1'b0;
      end
      if (if_flush) r_i_served <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_d_pend) begin
            if (w_fault) begin
              r_d_served  <= 1'b1;
              r_fault     <= 1'b1;
              r_load_data <= '0;
            end else begin
              r_mem_we    <= me_mem_write_ena;
              r_mem_addr  <= {me_alu_out[ADDR_W-1:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_func3     <= me_func3;
              r_lane      <= me_alu_out[1:0];
            end
          end else if (w_i_pend && !if_flush) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= {if_addr[ADDR_W-1:2], 2'b00};
            r_mem_be   <= 4'b1111;
          end
        end
        ST_D_WAIT: begin
          if (mem.mem_rvalid) begin
            if (!r_mem_we) r_load_data <= w_load;
            r_d_served <= 1'b1;
            r_fault    <= 1'b0;
          end
        end
        ST_I_REQ: begin
          if (if_flush) r_discard <= 1'b1;
        end
        ST_I_WAIT: begin
          if (mem.mem_rvalid) begin
            // A redirect landing on the response beat also kills the data.
            if (!r_discard && !if_flush) begin
              r_if_rdata <= mem.mem_rdata;
              r_i_served <= 1'b1;
            end
            r_discard <= 1'b0;
          end else if (if_flush) begin
            r_discard <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple grant/response memory model.
module tb_mem_port_arbiter;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, stall_if;
  logic [31:0] if_addr, if_rdata;
  logic        me_mem_read_ena, me_mem_write_ena;
  logic [31:0] me_alu_out, me_rs2_data_st, me_load_data;
  logic [2:0]  me_func3;
  logic        me_access_fault, stall_me, pipe_stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_flush         (if_flush),
    .if_rdata         (if_rdata),
    .stall_if         (stall_if),
    .me_mem_read_ena  (me_mem_read_ena),
    .me_mem_write_ena (me_mem_write_ena),
    .me_alu_out       (me_alu_out),
    .me_rs2_data_st   (me_rs2_data_st),
    .me_func3         (me_func3),
    .me_load_data     (me_load_data),
    .me_access_fault  (me_access_fault),
    .stall_me         (stall_me),
    .pipe_stall       (pipe_stall),
    .mem              (bus)
  );

  // Memory model: grant when enabled, response lat cycles after the grant.
  logic        gnt_en;
  int          lat;
  int          cnt;
  logic [31:0] pend_addr;
  logic [31:0] rd_word;

  assign bus.mem_gnt = bus.mem_req & gnt_en;

  function automatic logic [31:0] model(input logic [31:0] a);
    if (a == 32'h40) return 32'hAAAA_0040;
    if (a == 32'h80) return 32'hBBBB_0080;
    return rd_word;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cnt            <= 0;
      bus.mem_rvalid <= 1'b0;
      bus.mem_rdata  <= '0;
    end else begin
      bus.mem_rvalid <= 1'b0;
      if (bus.mem_req && bus.mem_gnt) begin
        if (lat <= 1) begin
          bus.mem_rvalid <= 1'b1;
          bus.mem_rdata  <= model(bus.mem_addr);
        end else begin
          cnt       <= lat - 1;
          pend_addr <= bus.mem_addr;
        end
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          bus.mem_rvalid <= 1'b1;
          bus.mem_rdata  <= model(pend_addr);
        end
      end
    end
  end

  int          req_cnt = 0;
  logic [31:0] log_addr  [64];
  logic [31:0] log_wdata [64];
  logic [3:0]  log_be    [64];
  logic        log_we    [64];

  always @(posedge clk) begin
    if (!reset && bus.mem_req && bus.mem_gnt) begin
      log_addr[req_cnt % 64]  <= bus.mem_addr;
      log_wdata[req_cnt % 64] <= bus.mem_wdata;
      log_be[req_cnt % 64]    <= bus.mem_be;
      log_we[req_cnt % 64]    <= bus.mem_we;
      req_cnt <= req_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if_req = 0; if_flush = 0; if_addr = 0;
    me_mem_read_ena = 0; me_mem_write_ena = 0;
    me_alu_out = 0; me_rs2_data_st = 0; me_func3 = F3_W;
  endtask

  task automatic wait_served(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (pipe_stall && cyc < 60) begin
      cyc++;
      tick();
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1; idle_inputs(); if_req = 1;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
    checks++; if ({bus.mem_we, bus.mem_be} !== 5'b0) begin failures++; $display("FAIL rst_we_be: got %b want 0", {bus.mem_we, bus.mem_be}); end
    checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
    checks++; if ({if_rdata, me_load_data} !== 64'h0) begin failures++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, me_load_data}); end
    checks++; if (me_access_fault !== 1'b0) begin failures++; $display("FAIL rst_fault: got %b want 0", me_access_fault); end
    checks++; if ({stall_if, stall_me, pipe_stall} !== 3'b101) begin failures++; $display("FAIL rst_stall_pend: got %b want 101", {stall_if, stall_me, pipe_stall}); end
    if_req = 0; #1;
    checks++; if ({stall_if, stall_me, pipe_stall} !== 3'b000) begin failures++; $display("FAIL rst_stall_idle: got %b want 000", {stall_if, stall_me, pipe_stall}); end
    tick(); reset = 0;
  endtask

  task automatic test_load_word;
    int cyc, base;
    tick();
    base = req_cnt; rd_word = 32'hDEAD_BEEF;
    me_mem_read_ena = 1; me_func3 = F3_W; me_alu_out = 32'h100;
    wait_served(cyc);
    checks++; if (cyc !== 3) begin failures++; $display("FAIL lw_stall_cycles: got %0d want 3", cyc); end
    checks++; if (me_load_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_data: got %h want deadbeef", me_load_data); end
    checks++; if ({log_addr[base % 64], log_be[base % 64], log_we[base % 64]} !== {32'h100, 4'b1111, 1'b0})
      begin failures++; $display("FAIL lw_bus: got addr=%h be=%b we=%b want 100/1111/0", log_addr[base % 64], log_be[base % 64], log_we[base % 64]); end
    checks++; if (req_cnt !== base + 1) begin failures++; $display("FAIL lw_req_count: got %0d want %0d", req_cnt - base, 1); end
    idle_inputs();
  endtask

  task automatic test_load_byte;
    int cyc, base;
    tick();
    base = req_cnt; rd_word = 32'h80FF_FFFF;
    me_mem_read_ena = 1; me_func3 = F3_B; me_alu_out = 32'h103;
    wait_served(cyc);
    checks++; if (me_load_data !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_sext: got %h want ffffff80", me_load_data); end
    checks++; if ({log_addr[base % 64], log_be[base % 64]} !== {32'h100, 4'b1000})
      begin failures++; $display("FAIL lb_bus: got addr=%h be=%b want 100/1000", log_addr[base % 64], log_be[base % 64]); end
    idle_inputs();
    tick();
    me_mem_read_ena = 1; me_func3 = F3_BU; me_alu_out = 32'h103;
    wait_served(cyc);
    checks++; if (me_load_data !== 32'h0000_0080) begin failures++; $display("FAIL lbu_zext: got %h want 00000080", me_load_data); end
    idle_inputs();
  endtask

  task automatic test_store_half;
    int cyc, base;
    tick();
    base = req_cnt;
    me_mem_write_ena = 1; me_func3 = F3_H; me_alu_out = 32'h202; me_rs2_data_st = 32'h1234_ABCD;
    wait_served(cyc);
    checks++; if (cyc !== 3) begin failures++; $display("FAIL sh_stall_cycles: got %0d want 3", cyc); end
    checks++; if ({log_we[base % 64], log_addr[base % 64], log_be[base % 64]} !== {1'b1, 32'h200, 4'b1100})
      begin failures++; $display("FAIL sh_bus: got we=%b addr=%h be=%b want 1/200/1100", log_we[base % 64], log_addr[base % 64], log_be[base % 64]); end
    checks++; if (log_wdata[base % 64] !== 32'hABCD_ABCD) begin failures++; $display("FAIL sh_wdata: got %h want abcdabcd", log_wdata[base % 64]); end
    idle_inputs();
  endtask

  task automatic test_fault;
    int base;
    base = req_cnt;
    tick();
    me_mem_read_ena = 1; me_func3 = F3_W; me_alu_out = 32'h101;
    @(negedge clk);
    checks++; if ({stall_me, me_access_fault} !== 2'b10) begin failures++; $display("FAIL flt_c0: got stall_me,fault=%b want 10", {stall_me, me_access_fault}); end
    tick(); @(negedge clk);
    checks++; if ({stall_me, me_access_fault, bus.mem_req} !== 3'b010) begin failures++; $display("FAIL flt_lw_misal: got stall_me,fault,req=%b want 010", {stall_me, me_access_fault, bus.mem_req}); end
    checks++; if (me_load_data !== 32'h0) begin failures++; $display("FAIL flt_data: got %h want 0", me_load_data); end
    idle_inputs();
    tick(); @(negedge clk);
    checks++; if (me_access_fault !== 1'b0) begin failures++; $display("FAIL flt_clear: got %b want 0", me_access_fault); end
    me_mem_read_ena = 1; me_func3 = 3'b011; me_alu_out = 32'h100;
    tick(); @(negedge clk);
    checks++; if (me_access_fault !== 1'b1) begin failures++; $display("FAIL flt_func3: got %b want 1", me_access_fault); end
    idle_inputs();
    tick();
    me_mem_read_ena = 1; me_mem_write_ena = 1; me_func3 = F3_W; me_alu_out = 32'h100;
    tick(); @(negedge clk);
    checks++; if (me_access_fault !== 1'b1) begin failures++; $display("FAIL flt_rd_wr: got %b want 1", me_access_fault); end
    idle_inputs();
    tick(); @(negedge clk);
    me_mem_write_ena = 1; me_func3 = F3_HU; me_alu_out = 32'h100;
    tick(); @(negedge clk);
    checks++; if (me_access_fault !== 1'b1) begin failures++; $display("FAIL flt_store_hu: got %b want 1", me_access_fault); end
    checks++; if (req_cnt !== base) begin failures++; $display("FAIL flt_no_access: got %0d requests want 0", req_cnt - base); end
    idle_inputs();
  endtask

  task automatic test_arbitration;
    int base;
    tick();
    base = req_cnt; rd_word = 32'h1234_5678;
    me_mem_read_ena = 1; me_func3 = F3_W; me_alu_out = 32'h10;
    if_req = 1; if_addr = 32'h40;
    @(negedge clk);
    checks++; if ({stall_if, stall_me} !== 2'b11) begin failures++; $display("FAIL arb_c0: got %b want 11", {stall_if, stall_me}); end
    tick(); @(negedge clk);
    checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h10}) begin failures++; $display("FAIL arb_data_first: got req=%b addr=%h want 1/10", bus.mem_req, bus.mem_addr); end
    tick(); tick(); @(negedge clk);
    checks++; if ({stall_me, stall_if, pipe_stall} !== 3'b011) begin failures++; $display("FAIL arb_c3: got me,if,pipe=%b want 011", {stall_me, stall_if, pipe_stall}); end
    tick(); @(negedge clk);
    checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h40}) begin failures++; $display("FAIL arb_fetch_second: got req=%b addr=%h want 1/40", bus.mem_req, bus.mem_addr); end
    tick(); tick(); @(negedge clk);
    checks++; if ({pipe_stall, bus.mem_req} !== 2'b00) begin failures++; $display("FAIL arb_done: got pipe,req=%b want 00", {pipe_stall, bus.mem_req}); end
    checks++; if ({if_rdata, me_load_data} !== {32'hAAAA_0040, 32'h1234_5678}) begin failures++; $display("FAIL arb_data: got if=%h ld=%h want aaaa0040/12345678", if_rdata, me_load_data); end
    checks++; if (req_cnt !== base + 2) begin failures++; $display("FAIL arb_req_count: got %0d want 2", req_cnt - base); end
    idle_inputs();
  endtask

  task automatic test_flush_wait;
    int cyc, base;
    lat = 3;
    tick();
    base = req_cnt;
    if_req = 1; if_addr = 32'h40;
    tick(); tick();
    if_flush = 1; if_addr = 32'h80;
    tick();
    if_flush = 0;
    wait_served(cyc);
    checks++; if (pipe_stall !== 1'b0) begin failures++; $display("FAIL flw_served: got pipe_stall=%b want 0", pipe_stall); end
    checks++; if (if_rdata !== 32'hBBBB_0080) begin failures++; $display("FAIL flw_rdata: got %h want bbbb0080", if_rdata); end
    checks++; if ({log_addr[base % 64], log_addr[(base + 1) % 64]} !== {32'h40, 32'h80}) begin failures++; $display("FAIL flw_reissue: got %h,%h want 40,80", log_addr[base % 64], log_addr[(base + 1) % 64]); end
    checks++; if (req_cnt !== base + 2) begin failures++; $display("FAIL flw_req_count: got %0d want 2", req_cnt - base); end
    lat = 1;
    idle_inputs();
  endtask

  task automatic test_flush_rvalid;
    int cyc, base;
    tick();
    base = req_cnt; rd_word = 32'hCAFE_00C0;
    if_req = 1; if_addr = 32'h40;
    tick(); tick();
    if_flush = 1; if_addr = 32'hC0;
    @(negedge clk);
    checks++; if ((bus.mem_rvalid !== 1'b1) || (stall_if !== 1'b1)) begin failures++; $display("FAIL flr_same_cycle: got rvalid=%b stall_if=%b want 1/1", bus.mem_rvalid, stall_if); end
    tick();
    if_flush = 0;
    wait_served(cyc);
    checks++; if (if_rdata !== 32'hCAFE_00C0) begin failures++; $display("FAIL flr_rdata: got %h want cafe00c0", if_rdata); end
    checks++; if ({req_cnt - base, log_addr[(base + 1) % 64]} !== {32'd2, 32'hC0}) begin failures++; $display("FAIL flr_reissue: got n=%0d addr=%h want 2/c0", req_cnt - base, log_addr[(base + 1) % 64]); end
    idle_inputs();
  endtask

  task automatic test_fetch_only;
    int cyc, base;
    tick();
    base = req_cnt;
    if_req = 1; if_addr = 32'h80;
    wait_served(cyc);
    checks++; if (cyc !== 3) begin failures++; $display("FAIL if_stall_cycles: got %0d want 3", cyc); end
    checks++; if (if_rdata !== 32'hBBBB_0080) begin failures++; $display("FAIL if_rdata: got %h want bbbb0080", if_rdata); end
    checks++; if ({log_addr[base % 64], log_be[base % 64], log_we[base % 64]} !== {32'h80, 4'b1111, 1'b0}) begin failures++; $display("FAIL if_bus: got addr=%h be=%b we=%b want 80/1111/0", log_addr[base % 64], log_be[base % 64], log_we[base % 64]); end
    idle_inputs();
  endtask

  task automatic test_back_to_back;
    int cyc, base;
    tick();
    base = req_cnt; rd_word = 32'h0BAD_F00D;
    me_mem_read_ena = 1; me_func3 = F3_W; me_alu_out = 32'h100;
    wait_served(cyc);
    checks++; if (me_load_data !== 32'h0BAD_F00D) begin failures++; $display("FAIL b2b_first: got %h want 0badf00d", me_load_data); end
    me_mem_read_ena = 0; me_mem_write_ena = 1; me_alu_out = 32'h104; me_rs2_data_st = 32'hCAFE_BABE;
    gnt_en = 0;
    tick(); tick(); @(negedge clk);
    checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 32'h104}) begin failures++; $display("FAIL b2b_req: got req=%b we=%b addr=%h want 1/1/104", bus.mem_req, bus.mem_we, bus.mem_addr); end
    tick(); @(negedge clk);
    checks++; if ({bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {1'b1, 32'h104, 32'hCAFE_BABE, 4'b1111})
      begin failures++; $display("FAIL b2b_hold: got req=%b addr=%h wdata=%h be=%b", bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_be); end
    gnt_en = 1;
    wait_served(cyc);
    checks++; if (cyc !== 1) begin failures++; $display("FAIL b2b_tail: got %0d want 1", cyc); end
    checks++; if ({req_cnt - base, log_addr[(base + 1) % 64]} !== {32'd2, 32'h104}) begin failures++; $display("FAIL b2b_log: got n=%0d addr=%h want 2/104", req_cnt - base, log_addr[(base + 1) % 64]); end
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    int cyc;
    lat = 3;
    tick();
    me_mem_read_ena = 1; me_func3 = F3_W; me_alu_out = 32'h10;
    tick(); tick();
    reset = 1;
    tick(); @(negedge clk);
    checks++; if ({bus.mem_req, stall_me} !== 2'b01) begin failures++; $display("FAIL rmid_req: got req,stall_me=%b want 01", {bus.mem_req, stall_me}); end
    checks++; if ({me_load_data, if_rdata} !== 64'h0) begin failures++; $display("FAIL rmid_data: got %h want 0", {me_load_data, if_rdata}); end
    idle_inputs(); reset = 0; lat = 1;
    tick(); @(negedge clk);
    checks++; if ({bus.mem_req, stall_me} !== 2'b00) begin failures++; $display("FAIL rmid_idle: got req,stall_me=%b want 00", {bus.mem_req, stall_me}); end
    rd_word = 32'h5A5A_5A5A;
    tick();
    me_mem_read_ena = 1; me_func3 = F3_W; me_alu_out = 32'h100;
    wait_served(cyc);
    checks++; if ({cyc[7:0], me_load_data} !== {8'd3, 32'h5A5A_5A5A}) begin failures++; $display("FAIL rmid_after: got cyc=%0d data=%h want 3/5a5a5a5a", cyc, me_load_data); end
    idle_inputs();
  endtask

  initial begin
    gnt_en = 1; lat = 1; rd_word = 0;
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_fault();
    test_arbitration();
    test_flush_wait();
    test_flush_rvalid();
    test_fetch_only();
    test_back_to_back();
    test_reset_mid();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbiter and sequencer for the single shared memory port of the 5-stage RISC-V pipeline. It serves instruction fetch (IF) and the EX/MEM-stage load/store as one-outstanding-transaction memory accesses. Data (MEM) requests have priority over fetch. The block generates stall_if, stall_me and pipe_stall, which freeze the pipeline registers. It also performs RV32 byte-enable generation, load extraction and alignment checking.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; fixed at 32, and byte-lane logic assumes 4 lanes

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch requested at if_addr
if_addr  in  ADDR_W  fetch PC, word aligned
if_flush  in  1  redirect; discard any fetch in flight or already served
if_rdata  out  DATA_W  fetched instruction; valid while i_served=1
stall_if  out  1  fetch not yet served
me_mem_read_ena  in  1  load in MEM stage
me_mem_write_ena  in  1  store in MEM stage
me_alu_out  in  ADDR_W  effective address
me_rs2_data_st  in  DATA_W  store data
me_func3  in  3  access size and sign
me_load_data  out  DATA_W  extended load result; valid while d_served=1
me_access_fault  out  1  misaligned address, illegal func3, or read and write both high
stall_me  out  1  data access not yet served
pipe_stall  out  1  stall_if | stall_me
mem_req  out  1  request valid; held high until mem_gnt
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word address, bits [1:0] = 0
mem_be  out  4  byte enables
mem_wdata  out  DATA_W  write data, lane-replicated
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  response; also acknowledges writes; arrives at least 1 cycle after gnt
mem_rdata  in  DATA_W  read data

Behaviour:
- Flags:
  - d_pend = (rd|wr) & ~d_served
  - i_pend = if_req & ~i_served
  - stall_me = d_pend
  - stall_if = i_pend
  - pipe_adv = ~pipe_stall
- On any clk edge with pipe_adv=1: clear d_served and i_served. This is how the pipeline moves to the next instruction.
- FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT.
- IDLE:
  - If d_pend and fault: set d_served, me_access_fault=1, me_load_data=0, no memory access.
  - Otherwise, if d_pend: latch addr, be, wdata and we, then go to D_REQ.
  - Otherwise, if i_pend and ~if_flush: latch if_addr, then go to I_REQ.
- D_REQ / I_REQ: mem_req=1 with latched fields stable. On mem_gnt, go to D_WAIT / I_WAIT.
- D_WAIT, on mem_rvalid:
  - Load: capture extracted data into me_load_data.
  - Set d_served and go to IDLE.
- I_WAIT, on mem_rvalid:
  - If discard=0: capture if_rdata and set i_served.
  - Clear discard and go to IDLE.
- Minimum stall, with gnt and rvalid immediate: request seen in cycle 0, mem_req in cycle 1, rvalid in cycle 2, stall low in cycle 3.
- Byte enables and write data:
  - sb (000): be = 0001<<a[1:0]
  - sh (001): be = 0011<<{a[1],1'b0}
  - sw (010): be = 1111
  - mem_wdata replicates the byte or half across all lanes.
- Loads (lane selected by a[1:0]):
  - 000 lb and 001 lh: sign-extended.
  - 100 lbu and 101 lhu: zero-extended.
  - 010 lw: full word.
- Faults:
  - lh, lhu or sh with a[0]=1.
  - lw or sw with a[1:0]≠0.
  - Any other func3.
  - rd and wr both high.
  - me_access_fault stays high while d_served is held from a fault. It is 0 otherwise.
- Simultaneous data and fetch pending in IDLE: data wins.
- Fetch served when the instruction in MEM needs no memory access: allowed.
- if_flush:
  - Clears i_served.
  - In I_REQ or I_WAIT, sets discard. The transaction completes on the bus but its data is dropped, then the fetch is re-issued with the new if_addr.
  - Never affects data state.
- Flush in the same cycle as I_WAIT rvalid: result discarded.
- Reset, including mid-transaction:
  - state=IDLE; d_served, i_served and discard = 0.
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, if_rdata=0, me_load_data=0, me_access_fault=0.
  - Memory shares the reset, so no stale rvalid arrives.
- Stall values at reset follow the combinational definitions above.
- mem_req never deasserts before mem_gnt. Latched fields are stable while mem_req=1.

Decomposition:
- Shared package riscv_pkg holds:
  - func3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The arbiter state enum.
- One sub-module, lsu_align, is purely combinational. It maps func3, a[1:0], rs2 data and rdata to be, wdata, load data and fault.

Test Plan:
- Load word: lw at 0x100, mem_rdata=0xDEADBEEF, gnt and rvalid immediate. Required: mem_addr=0x100, be=1111, stall_me high 3 cycles, me_load_data=0xDEADBEEF.
- lb sign extension: lb at 0x103, rdata=0x80FFFFFF → be-independent result 0xFFFFFF80. The same access as lbu → 0x00000080.
- sh at 0x202 with rs2=0x1234ABCD. Required: mem_we=1, mem_addr=0x200, be=1100, wdata=0xABCDABCD. stall_me drops after rvalid.
- Fetch and load pending together in IDLE. Required: data issued first; fetch issued after d_served; pipe_stall low only once both are served; neither is re-issued before pipe_adv.
- lw at 0x101. Required: no mem_req; me_access_fault=1 the next cycle; stall_me low.
- if_flush during I_WAIT, with old fetch 0x40 and new fetch 0x80. Required: the rdata for 0x40 is dropped; a second request to 0x80 is issued; if_rdata is the 0x80 data. A reset asserted in D_WAIT returns state to IDLE with mem_req=0.
